// File: rtl/xps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, clock deglitch filter, frame FSM
// with bit-gap timeout, and a first-word-fall-through scan-code FIFO.
module xps2_rx_fifo #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned CHECK_PARITY   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sel,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [8:0]                    data_out,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK
    } state_t;

    // Input path
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_s, dat_s;
    logic                   fclk_q, fclk_d;
    logic [FLT_W-1:0]       flt_cnt_q, flt_cnt_d;
    logic                   fall_q, fall_d;

    // Frame FSM
    state_t                 state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [10:0]            shift_q, shift_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   frame_err_q, frame_err_d;
    logic                   push_q, push_d;
    logic [7:0]             push_byte_q, push_byte_d;
    logic                   frame_ok;

    // FIFO
    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   fifo_full, do_push, do_pop;

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];

    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};

        // fclk flips on the FILTER_LEN-th consecutive differing sample
        fclk_d    = fclk_q;
        flt_cnt_d = '0;
        if (clk_s != fclk_q) begin
            if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                fclk_d = clk_s;
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
        fall_d = fclk_q & ~fclk_d;
    end

    // shift_q holds {stop, parity, data[7:0], start} once all 11 bits are in
    assign frame_ok = shift_q[10] && !shift_q[0] &&
                      ((CHECK_PARITY == 0) || (^shift_q[9:1]));

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        to_cnt_d    = to_cnt_q;
        frame_err_d = 1'b0;
        push_d      = 1'b0;
        push_byte_d = push_byte_q;

        case (state_q)
            S_IDLE: begin
                to_cnt_d = '0;
                if (fall_q) begin
                    if (!dat_s) begin
                        state_d   = S_SHIFT;
                        bit_cnt_d = 4'd1;
                        shift_d   = {dat_s, 10'b0};
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (fall_q) begin
                    shift_d   = {dat_s, shift_q[10:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    to_cnt_d  = '0;
                    if (bit_cnt_q == 4'd10) begin
                        state_d = S_CHECK;
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
                    state_d     = S_IDLE;
                    bit_cnt_d   = '0;
                    to_cnt_d    = '0;
                    frame_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
                if (frame_ok) begin
                    push_d      = 1'b1;
                    push_byte_d = shift_q[8:1];
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_pop    = sel && (count_q != '0);
    assign fifo_full = (count_q == LVL_W'(FIFO_DEPTH));
    assign do_push   = push_q && (!fifo_full || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q | (push_q & fifo_full & ~do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '1;
            dat_sync_q  <= '1;
            fclk_q      <= 1'b1;
            flt_cnt_q   <= '0;
            fall_q      <= 1'b0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            to_cnt_q    <= '0;
            frame_err_q <= 1'b0;
            push_q      <= 1'b0;
            push_byte_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            fclk_q      <= fclk_d;
            flt_cnt_q   <= flt_cnt_d;
            fall_q      <= fall_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            to_cnt_q    <= to_cnt_d;
            frame_err_q <= frame_err_d;
            push_q      <= push_d;
            push_byte_q <= push_byte_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_byte_q;
        end
    end

    assign data_out  = (count_q != '0) ? {1'b1, mem_q[rd_ptr_q]} : '0;
    assign frame_err = frame_err_q;
    assign overflow  = ovf_q;
    assign level     = count_q;

endmodule

// File: tb/tb_xps2_rx_fifo.sv
// Randomised bench for xps2_rx_fifo against a queue-based frame/FIFO model;
// two instances share the pins, one checking parity and one ignoring it.
module tb_xps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int SYNC  = 2;
    localparam int FILT  = 4;
    localparam int TO    = 300;
    localparam int HALF  = 20;
    localparam int LAT   = SYNC + FILT + 3;

    logic       clk, rst, sel, ps2_clk, ps2_data;
    logic [8:0] dout1, dout0;
    logic       ferr1, ferr0, ovf1, ovf0;
    logic [3:0] lvl1, lvl0;

    logic [7:0] mq1[$];
    logic [7:0] mq0[$];
    bit         movf1, movf0;
    int         merr1 = 0, merr0 = 0;
    int         seen1 = 0, seen0 = 0, run1 = 0, run0 = 0, maxrun1 = 0, maxrun0 = 0;
    int         checks = 0, failures = 0;

    xps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT),
                   .TIMEOUT_CYCLES(TO), .CHECK_PARITY(1)) dut (
        .clk(clk), .rst(rst), .sel(sel), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .data_out(dout1), .frame_err(ferr1), .overflow(ovf1), .level(lvl1));

    xps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT),
                   .TIMEOUT_CYCLES(TO), .CHECK_PARITY(0)) dut_np (
        .clk(clk), .rst(rst), .sel(sel), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .data_out(dout0), .frame_err(ferr0), .overflow(ovf0), .level(lvl0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (ferr1) seen1++;
            if (ferr0) seen0++;
            run1 = ferr1 ? run1 + 1 : 0;
            run0 = ferr0 ? run0 + 1 : 0;
            if (run1 > maxrun1) maxrun1 = run1;
            if (run0 > maxrun0) maxrun0 = run0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] head1();
        return (mq1.size() > 0) ? {1'b1, mq1[0]} : 9'h000;
    endfunction

    function automatic logic [8:0] head0();
        return (mq0.size() > 0) ? {1'b1, mq0[0]} : 9'h000;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_dout1"}, dout1, head1());
        check({tag, "_dout0"}, dout0, head0());
        check({tag, "_lvl1"}, lvl1, mq1.size());
        check({tag, "_lvl0"}, lvl0, mq0.size());
        check({tag, "_ovf1"}, ovf1, movf1);
        check({tag, "_ovf0"}, ovf0, movf0);
        check({tag, "_errs1"}, seen1, merr1);
        check({tag, "_errs0"}, seen0, merr0);
    endtask

    // Pop (if non-empty) happens before the push, so full+pop+push fits.
    task automatic model_apply(input bit g1, input bit g0, input logic [7:0] b, input bit popped);
        if (popped && mq1.size() > 0) void'(mq1.pop_front());
        if (popped && mq0.size() > 0) void'(mq0.pop_front());
        if (g1) begin
            if (mq1.size() == DEPTH) movf1 = 1'b1; else mq1.push_back(b);
        end else merr1++;
        if (g0) begin
            if (mq0.size() == DEPTH) movf0 = 1'b1; else mq0.push_back(b);
        end else merr0++;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit d);
        @(negedge clk);
        ps2_data = d;
        wait_n(HALF);
        ps2_clk = 1'b0;
        wait_n(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic do_pop();
        @(negedge clk);
        sel = 1'b1;
        @(posedge clk);
        #1;
        sel = 1'b0;
        if (mq1.size() > 0) void'(mq1.pop_front());
        if (mq0.size() > 0) void'(mq0.pop_front());
        check_state("pop");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        wait_n(2);
        rst = 1'b0;
        mq1.delete();
        mq0.delete();
        movf1 = 1'b0;
        movf0 = 1'b0;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic p;
        p = (~^b) ^ bad_par;
        return {~bad_stop, p, b, 1'b0};
    endfunction

    // Last falling edge is timed cycle by cycle to pin down latency and frame_err.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit sel_push);
        logic [10:0] bits;
        bit          g1, g0;
        bits = frame_bits(b, bad_par, bad_stop);
        g0 = bits[10];
        g1 = bits[10] && (^bits[9:1]);
        for (int i = 0; i < 10; i++) send_bit(bits[i]);
        @(negedge clk);
        ps2_data = bits[10];
        wait_n(HALF);
        ps2_clk = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk);
            #1;
            if (k == LAT - 1) begin
                check("ferr1_at_check", ferr1, !g1);
                check("ferr0_at_check", ferr0, !g0);
                check("dout1_before", dout1, head1());
                check("lvl1_before", lvl1, mq1.size());
                if (sel_push) sel = 1'b1;
            end
            if (k == LAT) begin
                sel = 1'b0;
                model_apply(g1, g0, b, sel_push);
                check("ferr1_after", ferr1, 0);
                check_state("frame");
            end
        end
        wait_n(HALF - LAT);
        ps2_clk = 1'b1;
        wait_n(2 * HALF);
    endtask

    initial begin
        logic [10:0] fb;
        rst = 1'b1; sel = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        movf1 = 1'b0; movf0 = 1'b0;
        wait_n(4);
        check("rst_ferr1", ferr1, 0);
        check("rst_ferr0", ferr0, 0);
        check_state("reset");
        rst = 1'b0;
        wait_n(10);

        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check("good_1c", dout1, 9'h11C);
        check("good_lvl", lvl1, 1);
        do_pop();
        check("pop_to_empty", dout1, 9'h000);

        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        check("badpar_rejected", dout1, 9'h000);
        check("nopar_accepted", dout0, 9'h11C);
        do_pop();

        send_bit(1'b1);
        merr1++; merr0++;
        wait_n(10);
        check_state("bad_start");

        fb = frame_bits(8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(fb[i]);
        wait_n(TO / 2);
        check("to_early1", seen1, merr1);
        wait_n(TO);
        merr1++; merr0++;
        check_state("timeout");
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check("after_to_5a", dout1, 9'h15A);
        do_pop();

        for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        check("ovf_level", lvl1, DEPTH);
        check("ovf_flag", ovf1, 1);
        for (int i = 1; i <= DEPTH; i++) begin
            check("ovf_order", dout1, {1'b1, 8'(i)});
            do_pop();
        end
        check("ovf_drained", dout1, 9'h000);

        for (int g = 1; g < FILT; g++) begin
            repeat (2) begin
                @(negedge clk);
                ps2_clk = 1'b0;
                wait_n(g);
                ps2_clk = 1'b1;
                wait_n(15);
            end
        end
        check_state("glitch");

        fb = frame_bits(8'h33, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) send_bit(fb[i]);
        do_reset();
        wait_n(10);
        check_state("mid_reset");
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        check("after_rst_f0", dout1, 9'h1F0);
        do_pop();

        for (int i = 0; i < DEPTH; i++) send_frame(8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
        send_frame(8'hBB, 1'b0, 1'b0, 1'b1);
        check("fullpp_level", lvl1, DEPTH);
        check("fullpp_ovf", ovf1, 0);
        for (int i = 0; i < DEPTH - 1; i++) do_pop();
        check("fullpp_last", dout1, 9'h1BB);
        do_pop();

        for (int n = 0; n < 30; n++) begin
            send_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) do_pop();
            end
        end
        while (mq1.size() > 0 || mq0.size() > 0) do_pop();

        check("err_width1", maxrun1, 1);
        check("err_width0", maxrun0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
